// File: rtl/vending_fsm_multi.sv
// vending_fsm_multi: parametrised vending-machine controller.
// Collects coins into a bounded credit, dispenses one of N_PROD products
// at per-product prices, returns change, and supports cancel and an
// inactivity timeout that refunds automatically.
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   coin_valid/coin_val       coin presented / its value
//   coin_ready                combinational: coin accepted this cycle if coin_valid
//   sel_valid/sel_idx         product selection strobe / index
//   cancel                    refund request
//   vend_valid/vend_idx       one-cycle dispense pulse / product dispensed
//   change_valid/change_amt   change pending (held until change_ack) / amount
//   change_ack                change taken
//   err_valid/err_code        one-cycle error pulse / 1 = low credit, 2 = bad index
//   credit                    current credit
//   busy                      controller not idle
module vending_fsm_multi #(
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned COIN_W      = 4,
  parameter int unsigned N_PROD      = 4,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {6'd9, 6'd7, 6'd5, 6'd3},
  parameter int unsigned MAX_CREDIT  = 20,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_val,
  output logic                coin_ready,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_idx,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_idx,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  input  logic                change_ack,
  output logic                err_valid,
  output logic [1:0]          err_code,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  state_t              state;
  logic [TMR_W-1:0]    timer;
  logic [TMR_W-1:0]    timer_inc;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] price;
  logic                sel_bad;
  logic                coin_acc;

  // Price lookup by index; indices at or beyond N_PROD flag sel_bad
  always_comb begin
    price   = '0;
    sel_bad = 1'b1;
    for (int i = 0; i < int'(N_PROD); i++) begin
      if (sel_idx == SEL_W'(i)) begin
        price   = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_bad = 1'b0;
      end
    end
  end

  // Coin acceptance: only while collecting, never alongside a select/cancel,
  // and only if the sum (one bit wider than credit) stays within the ceiling
  always_comb begin
    coin_sum   = (CREDIT_W+1)'(credit) + (CREDIT_W+1)'(coin_val);
    coin_ready = ((state == ST_IDLE) || (state == ST_CREDIT)) && !sel_valid && !cancel &&
                 (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    coin_acc   = coin_valid && coin_ready;
    timer_inc  = timer + 1'b1;
  end

  // Controller state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      credit       <= '0;
      busy         <= 1'b0;
      vend_valid   <= 1'b0;
      vend_idx     <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      err_valid    <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      vend_valid <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= 2'd0;
      case (state)
        ST_IDLE: begin
          // a zero-value coin is accepted but leaves the machine idle
          if (coin_acc && (coin_val != '0)) begin
            credit <= CREDIT_W'(coin_sum);
            state  <= ST_CREDIT;
            busy   <= 1'b1;
            timer  <= '0;
          end
        end
        ST_CREDIT: begin
          if (cancel) begin
            state        <= ST_CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
            timer        <= '0;
          end else if (sel_valid) begin
            if (sel_bad) begin
              err_valid <= 1'b1;
              err_code  <= 2'd2;
            end else if (credit < price) begin
              err_valid <= 1'b1;
              err_code  <= 2'd1;
            end else begin
              state      <= ST_VEND;
              vend_valid <= 1'b1;
              vend_idx   <= sel_idx;
              credit     <= credit - price;
              timer      <= '0;
            end
          end else if (coin_acc) begin
            credit <= CREDIT_W'(coin_sum);
            timer  <= '0;
          end else if (TIMEOUT_CYC != 0) begin
            // refund once the idle count reaches the limit
            if (timer_inc == TMR_W'(TIMEOUT_CYC)) begin
              state        <= ST_CHANGE;
              change_valid <= 1'b1;
              change_amt   <= credit;
              timer        <= '0;
            end else begin
              timer <= timer_inc;
            end
          end
        end
        ST_VEND: begin
          if (credit != '0) begin
            state        <= ST_CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_CHANGE: begin
          if (change_ack) begin
            state        <= ST_IDLE;
            credit       <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            busy         <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Bench for vending_fsm_multi: a cycle model of the vending rules checked
// against the DUT on every falling edge, plus directed literal checks.
// A second instance with N_PROD=5 covers out-of-range product indices.
module tb_vending_fsm_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_val = 4'd0;
  logic       coin_ready;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_idx = 2'd0;
  logic       cancel = 1'b0;
  logic       vend_valid;
  logic [1:0] vend_idx;
  logic       change_valid;
  logic [5:0] change_amt;
  logic       change_ack = 1'b0;
  logic       err_valid;
  logic [1:0] err_code;
  logic [5:0] credit;
  logic       busy;

  // N_PROD=5 variant
  logic       d5_coin_valid = 1'b0;
  logic [3:0] d5_coin_val = 4'd0;
  logic       d5_coin_ready;
  logic       d5_sel_valid = 1'b0;
  logic [2:0] d5_sel_idx = 3'd0;
  logic       d5_vend_valid;
  logic [2:0] d5_vend_idx;
  logic       d5_change_valid;
  logic [5:0] d5_change_amt;
  logic       d5_err_valid;
  logic [1:0] d5_err_code;
  logic [5:0] d5_credit;
  logic       d5_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vending_fsm_multi dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_val(coin_val), .coin_ready(coin_ready),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .vend_valid(vend_valid), .vend_idx(vend_idx),
    .change_valid(change_valid), .change_amt(change_amt), .change_ack(change_ack),
    .err_valid(err_valid), .err_code(err_code), .credit(credit), .busy(busy)
  );

  vending_fsm_multi #(
    .N_PROD(5),
    .PRICES({6'd11, 6'd9, 6'd7, 6'd5, 6'd3})
  ) dut5 (
    .clk(clk), .rst(rst),
    .coin_valid(d5_coin_valid), .coin_val(d5_coin_val), .coin_ready(d5_coin_ready),
    .sel_valid(d5_sel_valid), .sel_idx(d5_sel_idx), .cancel(1'b0),
    .vend_valid(d5_vend_valid), .vend_idx(d5_vend_idx),
    .change_valid(d5_change_valid), .change_amt(d5_change_amt), .change_ack(1'b1),
    .err_valid(d5_err_valid), .err_code(d5_err_code), .credit(d5_credit), .busy(d5_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for money, 1 collecting, 2 dispensing, 3 returning change
  int m_mode = 0, m_credit = 0, m_idle = 0, m_vidx = 0, m_ecode = 0;
  bit m_vend = 0, m_err = 0, m_acc = 0, started = 0;

  function automatic int price_of(input int i);
    int tbl [4] = '{3, 5, 7, 9};
    return tbl[i];
  endfunction

  function automatic bit exp_ready();
    return (m_mode <= 1) && !sel_valid && !cancel && (m_credit + int'(coin_val) <= 20);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_credit = 0; m_idle = 0; m_vidx = 0;
      m_vend = 0; m_err = 0; m_ecode = 0;
      started = 1;
    end else begin
      m_acc  = coin_valid && exp_ready();
      m_vend = 0; m_err = 0; m_ecode = 0;
      case (m_mode)
        0: if (m_acc && coin_val != 0) begin m_credit += int'(coin_val); m_mode = 1; m_idle = 0; end
        1: begin
          if (cancel) begin m_mode = 3; m_idle = 0; end
          else if (sel_valid) begin
            if (m_credit < price_of(int'(sel_idx))) begin m_err = 1; m_ecode = 1; end
            else begin
              m_credit -= price_of(int'(sel_idx));
              m_vend = 1; m_vidx = int'(sel_idx); m_mode = 2; m_idle = 0;
            end
          end else if (m_acc) begin m_credit += int'(coin_val); m_idle = 0; end
          else begin
            m_idle++;
            if (m_idle == 16) begin m_mode = 3; m_idle = 0; end
          end
        end
        2: m_mode = (m_credit > 0) ? 3 : 0;
        default: if (change_ack) begin m_credit = 0; m_mode = 0; end
      endcase
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("coin_ready", 32'(coin_ready), 32'(exp_ready()));
      chk("credit", 32'(credit), 32'(m_credit));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("vend_valid", 32'(vend_valid), 32'(m_vend));
      if (m_vend) chk("vend_idx", 32'(vend_idx), 32'(m_vidx));
      chk("change_valid", 32'(change_valid), 32'(m_mode == 3));
      chk("change_amt", 32'(change_amt), 32'((m_mode == 3) ? m_credit : 0));
      chk("err_valid", 32'(err_valid), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_ecode));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1; coin_val = 4'(v);
    cyc();
    coin_valid = 1'b0; coin_val = 4'd0;
  endtask

  task automatic sel(input int i);
    sel_valid = 1'b1; sel_idx = 2'(i);
    cyc();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1; cyc(); cancel = 1'b0;
  endtask

  task automatic ack();
    change_ack = 1'b1; cyc(); change_ack = 1'b0;
  endtask

  task automatic d5_sel(input int i);
    d5_sel_valid = 1'b1; d5_sel_idx = 3'(i);
    cyc();
    d5_sel_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_credit"}, 32'(credit), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_vend"}, 32'({vend_valid, vend_idx}), 0);
    chk({tag, "_change"}, 32'({change_valid, change_amt}), 0);
    chk({tag, "_err"}, 32'({err_valid, err_code}), 0);
  endtask

  initial begin
    int first;
    cyc(); cyc();
    chk_all_zero("reset");
    chk("d5_reset", 32'({d5_credit, d5_busy, d5_vend_valid, d5_change_valid, d5_err_valid}), 0);
    rst = 1'b0;

    // zero coin in idle is a no-op
    coin(0);
    chk("zero_coin_busy", 32'(busy), 0);

    // 1: insufficient credit, then exact vend with no change
    coin(2); coin(2);
    chk("t1_credit4", 32'(credit), 4);
    chk("t1_model_credit4", 32'(m_credit), 4);
    sel(1);
    chk("t1_err", 32'({err_valid, err_code}), 32'({1'b1, 2'd1}));
    chk("t1_credit_kept", 32'(credit), 4);
    coin(1);
    sel(1);
    chk("t1_vend", 32'({vend_valid, vend_idx}), 32'({1'b1, 2'd1}));
    chk("t1_credit0", 32'(credit), 0);
    cyc();
    chk("t1_vend_pulse", 32'(vend_valid), 0);
    chk("t1_busy_low", 32'(busy), 0);
    chk("t1_no_change", 32'(change_valid), 0);

    // 2: vend with change held until ack
    coin(5); coin(5);
    sel(0);
    chk("t2_vend", 32'({vend_valid, vend_idx}), 32'({1'b1, 2'd0}));
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t2_change_held", 32'({change_valid, change_amt}), 32'({1'b1, 6'd7}));
      cyc();
    end
    ack();
    chk("t2_after_ack", 32'({credit, busy, change_valid}), 0);

    // 3: credit ceiling
    coin(4); coin(4); coin(4); coin(4); coin(2);
    chk("t3_credit18", 32'(credit), 18);
    coin_valid = 1'b1; coin_val = 4'd5;
    #1 chk("t3_ready_low", 32'(coin_ready), 0);
    cyc();
    coin_valid = 1'b0;
    chk("t3_credit_stays", 32'(credit), 18);
    coin(2);
    chk("t3_credit20", 32'(credit), 20);
    do_cancel();
    chk("t3_refund20", 32'(change_amt), 20);
    ack();

    // 4: cancel refund, then inactivity timeout
    coin(4); coin(2);
    do_cancel();
    chk("t4_cancel", 32'({change_valid, change_amt}), 32'({1'b1, 6'd6}));
    ack();
    coin(2);
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (change_valid && first < 0) first = k;
    end
    chk("t4_timeout_latency", 32'(first), 16);
    chk("t4_timeout_amt", 32'(change_amt), 2);
    ack();

    // 5: sel wins over a simultaneous coin
    coin(4);
    coin_valid = 1'b1; coin_val = 4'd3; sel_valid = 1'b1; sel_idx = 2'd0;
    #1 chk("t5_ready_low", 32'(coin_ready), 0);
    cyc();
    coin_valid = 1'b0; coin_val = 4'd0; sel_valid = 1'b0;
    chk("t5_vend", 32'({vend_valid, vend_idx}), 32'({1'b1, 2'd0}));
    chk("t5_credit1", 32'(credit), 1);
    cyc();
    ack();

    // 5b: N_PROD=5 instance, out-of-range indices
    d5_coin_valid = 1'b1; d5_coin_val = 4'd5;
    cyc();
    d5_coin_valid = 1'b0;
    chk("d5_credit5", 32'(d5_credit), 5);
    d5_sel(7);
    chk("d5_err_idx7", 32'({d5_err_valid, d5_err_code}), 32'({1'b1, 2'd2}));
    d5_sel(5);
    chk("d5_err_idx5", 32'({d5_err_valid, d5_err_code}), 32'({1'b1, 2'd2}));
    d5_sel(4);
    chk("d5_err_price4", 32'({d5_err_valid, d5_err_code}), 32'({1'b1, 2'd1}));
    d5_sel(1);
    chk("d5_vend", 32'({d5_vend_valid, d5_vend_idx, d5_credit}), 32'({1'b1, 3'd1, 6'd0}));
    cyc();
    chk("d5_idle", 32'({d5_busy, d5_change_valid, d5_change_amt, d5_coin_ready}), 32'({1'b0, 1'b0, 6'd0, 1'b1}));

    // 6: reset during change discards it
    coin(5); coin(5);
    sel(0);
    cyc();
    chk("t6_change7", 32'({change_valid, change_amt}), 32'({1'b1, 6'd7}));
    rst = 1'b1;
    cyc();
    chk_all_zero("t6_reset");
    rst = 1'b0;
    cyc(); cyc();
    chk("t6_still_idle", 32'({busy, credit}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
